// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS controller:
// state enum, opcode/funct values, ALU codes and datapath mux encodings.
package mips_mc_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALUC_W-1:0] ALUC_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALUC_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALUC_SLT = 3'b111;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Controller <-> multicycle datapath signal bundle: decode fields and
// handshake in, mux selects and write enables out.
interface mips_mc_controller_if;
    import mips_mc_pkg::*;

    logic [OP_W-1:0]    op;
    logic [FUNCT_W-1:0] funct;
    logic               zero;
    logic               mem_ready;

    logic               pcen;
    logic               iord;
    logic               memwrite;
    logic               irwrite;
    logic               regdst;
    logic               memtoreg;
    logic               regwrite;
    logic               alusrca;
    logic [SEL_W-1:0]   alusrcb;
    logic [SEL_W-1:0]   pcsrc;
    logic [ALUC_W-1:0]  alucontrol;
    state_t             state;

    modport master (
        input  op, funct, zero, mem_ready,
        output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, state
    );

endinterface

// File: rtl/mc_aludec.sv
// ALU decoder: fixed add/sub for address and branch work, funct decode
// for R-type; anything unrecognised falls back to add.
module mc_aludec
    import mips_mc_pkg::*;
(
    input  aluop_t              aluop,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUC_W-1:0]   alucontrol
);

    always_comb begin
        alucontrol = ALUC_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALUC_ADD;
            ALUOP_SUB: alucontrol = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    F_ADD:   alucontrol = ALUC_ADD;
                    F_SUB:   alucontrol = ALUC_SUB;
                    F_AND:   alucontrol = ALUC_AND;
                    F_OR:    alucontrol = ALUC_OR;
                    F_SLT:   alucontrol = ALUC_SLT;
                    default: alucontrol = ALUC_ADD;
                endcase
            end
            default: alucontrol = ALUC_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared-memory
// datapath, stalling in FETCH/MEMRD/MEMWR until the memory is ready.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    mips_mc_controller_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    aluop_t            aluop;
    logic              pcwrite_c;
    logic              branch_c;
    logic              irwrite_c;
    logic              memwrite_c;
    logic              regwrite_c;
    logic              iord;
    logic              regdst;
    logic              memtoreg;
    logic              alusrca;
    logic [SEL_W-1:0]  alusrcb;
    logic [SEL_W-1:0]  pcsrc;
    logic [ALUC_W-1:0] alucontrol;

    // Reset returns straight to FETCH so a half-done instruction is abandoned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pcwrite_c  = 1'b0;
        branch_c   = 1'b0;
        irwrite_c  = 1'b0;
        memwrite_c = 1'b0;
        regwrite_c = 1'b0;
        iord       = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = SRCB_B;
        pcsrc      = PCSRC_ALU;
        aluop      = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                alusrcb = SRCB_FOUR;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb = SRCB_IMMSH;
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PCSRC_ALUOUT;
                branch_c = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEXEC: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc     = PCSRC_JUMP;
                pcwrite_c = 1'b1;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (bus.funct),
        .alucontrol (alucontrol)
    );

    // Write enables are held off for the whole time reset is low.
    assign bus.pcen       = reset & (pcwrite_c | (branch_c & bus.zero));
    assign bus.irwrite    = reset & irwrite_c;
    assign bus.memwrite   = reset & memwrite_c;
    assign bus.regwrite   = reset & regwrite_c;
    assign bus.iord       = iord;
    assign bus.regdst     = regdst;
    assign bus.memtoreg   = memtoreg;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alucontrol;
    assign bus.state      = state_q;

endmodule
